// File: rtl/activation_package_serializer.sv
// Activation-package serial transmitter: parallel package in over valid/ready,
// MSB-first bit stream out with sof/eof markers and a one-entry holding buffer.
module activation_package_serializer #(
  parameter int PKT_W      = 60,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pkt_valid,
  output logic             pkt_ready,
  input  logic [PKT_W-1:0] pkt_data,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             sof,
  output logic             eof,
  output logic             busy,
  output logic [1:0]       o_dbg_state
);

  localparam int CNT_W = (PKT_W > 1) ? $clog2(PKT_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PKT_W - 1);
  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0]       r_state;
  logic [PKT_W-1:0] r_sh;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_gap;
  logic [PKT_W-1:0] r_hold;
  logic             r_hold_valid;

  logic w_xfer;
  logic w_last;

  // Handshake: a package moves on a rising edge where pkt_valid && pkt_ready.
  // pkt_ready depends only on the holding-buffer flag, never on pkt_valid.
  assign pkt_ready = !r_hold_valid;
  assign w_xfer    = pkt_valid && pkt_ready;
  assign w_last    = (r_state == ST_SHIFT) && (r_cnt == LAST_BIT);

  assign serial_valid = (r_state == ST_SHIFT);
  assign serial_out   = serial_valid && r_sh[PKT_W-1];
  assign sof          = serial_valid && (r_cnt == '0);
  assign eof          = w_last;
  assign busy         = (r_state != ST_IDLE) || r_hold_valid;
  assign o_dbg_state  = r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_sh         <= '0;
      r_cnt        <= '0;
      r_gap        <= '0;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_xfer) begin
            r_sh    <= pkt_data;
            r_state <= ST_SHIFT;
          end else if (r_hold_valid) begin
            r_sh         <= r_hold;
            r_hold_valid <= 1'b0;
            r_state      <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (!w_last) begin
            r_sh  <= r_sh << 1;
            r_cnt <= r_cnt + 1'b1;
            if (w_xfer) begin
              r_hold       <= pkt_data;
              r_hold_valid <= 1'b1;
            end
          end else if (GAP_CYCLES == 0) begin
            // Back-to-back: buffered package first, then same-edge bypass.
            r_cnt <= '0;
            if (r_hold_valid) begin
              r_sh         <= r_hold;
              r_hold_valid <= 1'b0;
            end else if (w_xfer) begin
              r_sh <= pkt_data;
            end else begin
              r_sh    <= '0;
              r_state <= ST_IDLE;
            end
          end else begin
            r_cnt   <= '0;
            r_sh    <= '0;
            r_gap   <= GAP_LOAD;
            r_state <= ST_GAP;
            if (w_xfer) begin
              r_hold       <= pkt_data;
              r_hold_valid <= 1'b1;
            end
          end
        end

        ST_GAP: begin
          if (w_xfer) begin
            r_hold       <= pkt_data;
            r_hold_valid <= 1'b1;
          end
          if (r_gap <= 8'd1) begin
            r_cnt <= '0;
            if (r_hold_valid) begin
              r_sh         <= r_hold;
              r_hold_valid <= 1'b0;
              r_state      <= ST_SHIFT;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_gap <= r_gap - 8'd1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_activation_package_serializer.sv
// Bench for activation_package_serializer: three instances (60-bit no gap,
// 60-bit three-cycle gap, 2-bit no gap) checked against a loader model and queues.
module tb_activation_package_serializer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  localparam logic [59:0] PAT_A = 60'hAAAAAAAAAAAAAAA;
  localparam logic [59:0] PAT_5 = 60'h555555555555555;

  logic        a_valid, a_ready, a_so, a_sv, a_sof, a_eof, a_busy;
  logic [59:0] a_data;
  logic [1:0]  a_st;
  logic        b_valid, b_ready, b_so, b_sv, b_sof, b_eof, b_busy;
  logic [59:0] b_data;
  logic [1:0]  b_st;
  logic        c_valid, c_ready, c_so, c_sv, c_sof, c_eof, c_busy;
  logic [1:0]  c_data;
  logic [1:0]  c_st;

  activation_package_serializer #(.PKT_W(60), .GAP_CYCLES(0)) u_a (
    .clk(clk), .reset(reset), .pkt_valid(a_valid), .pkt_ready(a_ready),
    .pkt_data(a_data), .serial_out(a_so), .serial_valid(a_sv), .sof(a_sof),
    .eof(a_eof), .busy(a_busy), .o_dbg_state(a_st));

  activation_package_serializer #(.PKT_W(60), .GAP_CYCLES(3)) u_b (
    .clk(clk), .reset(reset), .pkt_valid(b_valid), .pkt_ready(b_ready),
    .pkt_data(b_data), .serial_out(b_so), .serial_valid(b_sv), .sof(b_sof),
    .eof(b_eof), .busy(b_busy), .o_dbg_state(b_st));

  activation_package_serializer #(.PKT_W(2), .GAP_CYCLES(0)) u_c (
    .clk(clk), .reset(reset), .pkt_valid(c_valid), .pkt_ready(c_ready),
    .pkt_data(c_data), .serial_out(c_so), .serial_valid(c_sv), .sof(c_sof),
    .eof(c_eof), .busy(c_busy), .o_dbg_state(c_st));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboards / loader models ----------------
  logic [59:0] a_exp_q[$];
  logic [59:0] b_exp_q[$];
  logic [1:0]  c_exp_q[$];

  always @(posedge clk) begin
    if (!reset && a_valid && a_ready) a_exp_q.push_back(a_data);
    if (!reset && b_valid && b_ready) b_exp_q.push_back(b_data);
    if (!reset && c_valid && c_ready) c_exp_q.push_back(c_data);
  end

  int          a_idx = 0, a_run = 0, a_last_run = 0, a_frames = 0;
  logic [59:0] a_ld = '0;

  always @(negedge clk) begin
    if (reset) begin
      a_idx = 0;
      a_run = 0;
      a_exp_q.delete();
    end else if (a_sv) begin
      a_ld = {a_ld[58:0], a_so};
      check("a_sof", 64'(a_sof), 64'(a_idx == 0));
      check("a_eof", 64'(a_eof), 64'(a_idx == 59));
      a_run++;
      if (a_idx == 59) begin
        check("a_frame_expected", 64'(a_exp_q.size() > 0), 64'd1);
        if (a_exp_q.size() > 0) check("a_frame", 64'(a_ld), 64'(a_exp_q.pop_front()));
        a_frames++;
        a_idx = 0;
      end else begin
        a_idx++;
      end
    end else begin
      check("a_idle_bits", 64'({a_so, a_sof, a_eof}), 64'd0);
      check("a_frame_break", 64'(a_idx), 64'd0);
      if (a_run != 0) a_last_run = a_run;
      a_run = 0;
    end
  end

  int          b_idx = 0, b_frames = 0, b_gap_cnt = 0, b_last_gap = -1;
  logic        b_after_eof = 1'b0;
  logic [59:0] b_ld = '0;

  always @(negedge clk) begin
    if (reset) begin
      b_idx = 0;
      b_after_eof = 1'b0;
      b_exp_q.delete();
    end else if (b_sv) begin
      b_ld = {b_ld[58:0], b_so};
      if (b_idx == 0 && b_after_eof) begin
        b_last_gap  = b_gap_cnt;
        b_after_eof = 1'b0;
      end
      check("b_sof", 64'(b_sof), 64'(b_idx == 0));
      check("b_eof", 64'(b_eof), 64'(b_idx == 59));
      if (b_idx == 59) begin
        check("b_frame_expected", 64'(b_exp_q.size() > 0), 64'd1);
        if (b_exp_q.size() > 0) check("b_frame", 64'(b_ld), 64'(b_exp_q.pop_front()));
        b_frames++;
        b_idx = 0;
        b_after_eof = 1'b1;
        b_gap_cnt = 0;
      end else begin
        b_idx++;
      end
    end else begin
      check("b_idle_bits", 64'({b_so, b_sof, b_eof}), 64'd0);
      check("b_frame_break", 64'(b_idx), 64'd0);
      if (b_after_eof) b_gap_cnt++;
    end
  end

  int         c_idx = 0, c_run = 0, c_last_run = 0, c_frames = 0;
  logic [1:0] c_ld = '0;
  logic [7:0] c_seq = '0;

  always @(negedge clk) begin
    if (reset) begin
      c_idx = 0;
      c_run = 0;
      c_exp_q.delete();
    end else if (c_sv) begin
      c_ld  = {c_ld[0], c_so};
      c_seq = {c_seq[6:0], c_so};
      check("c_sof", 64'(c_sof), 64'(c_idx == 0));
      check("c_eof", 64'(c_eof), 64'(c_idx == 1));
      check("c_sof_and_eof", 64'(c_sof & c_eof), 64'd0);
      c_run++;
      if (c_idx == 1) begin
        check("c_frame_expected", 64'(c_exp_q.size() > 0), 64'd1);
        if (c_exp_q.size() > 0) check("c_frame", 64'(c_ld), 64'(c_exp_q.pop_front()));
        c_frames++;
        c_idx = 0;
      end else begin
        c_idx++;
      end
    end else begin
      check("c_idle_bits", 64'({c_so, c_sof, c_eof}), 64'd0);
      if (c_run != 0) c_last_run = c_run;
      c_run = 0;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic ready_of(input int which);
    case (which)
      0:       return a_ready;
      1:       return b_ready;
      default: return c_ready;
    endcase
  endfunction

  function automatic logic busy_of(input int which);
    case (which)
      0:       return a_busy;
      1:       return b_busy;
      default: return c_busy;
    endcase
  endfunction

  task automatic send(input int which, input logic [59:0] d, output int waits);
    logic [63:0] rnd;
    waits = 0;
    case (which)
      0:       begin a_valid = 1'b1; a_data = d; end
      1:       begin b_valid = 1'b1; b_data = d; end
      default: begin c_valid = 1'b1; c_data = d[1:0]; end
    endcase
    while (!ready_of(which) && waits < 1000) begin
      @(negedge clk);
      waits++;
    end
    check($sformatf("send%0d_ready", which), 64'(ready_of(which)), 64'd1);
    @(posedge clk);
    #1;
    rnd = {$urandom(), $urandom()};
    case (which)
      0:       begin a_valid = 1'b0; a_data = rnd[59:0]; end
      1:       begin b_valid = 1'b0; b_data = rnd[59:0]; end
      default: begin c_valid = 1'b0; c_data = rnd[1:0]; end
    endcase
  endtask

  task automatic wait_idle(input int which);
    int n = 0;
    while (busy_of(which) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("idle%0d_timeout", which), 64'(busy_of(which)), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int w;
    int n;
    int f0;
    logic [63:0] rnd;
    logic [59:0] px, py, pz;

    reset = 1'b1;
    a_valid = 1'b0; a_data = '0;
    b_valid = 1'b0; b_data = '0;
    c_valid = 1'b0; c_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_a_outputs", 64'({a_so, a_sv, a_sof, a_eof, a_busy}), 64'd0);
    check("rst_a_ready", 64'(a_ready), 64'd1);
    check("rst_a_state", 64'(a_st), 64'd0);
    check("rst_c_outputs", 64'({c_so, c_sv, c_sof, c_eof, c_busy, c_ready}), 64'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_rst_idle", 64'({a_sv, a_busy, a_ready}), 64'd1);

    // single frame, first bit one cycle after the transfer edge
    send(0, 60'h800000000000001, w);
    check("t1_wait", 64'(w), 64'd0);
    @(negedge clk);
    check("t1_first_valid", 64'(a_sv), 64'd1);
    check("t1_first_sof", 64'(a_sof), 64'd1);
    check("t1_first_bit", 64'(a_so), 64'd1);
    wait_idle(0);
    check("t1_run", 64'(a_last_run), 64'd60);
    check("t1_loader", 64'(a_ld), 64'(60'h800000000000001));

    // back-to-back alternating patterns, no gap
    send(0, PAT_A, w);
    send(0, PAT_5, w);
    check("t2_second_wait", 64'(w), 64'd0);
    wait_idle(0);
    check("t2_run", 64'(a_last_run), 64'd120);
    check("t2_loader", 64'(a_ld), 64'(PAT_5));

    // same-edge bypass at eof with an empty buffer
    rnd = {$urandom(), $urandom()}; px = rnd[59:0];
    rnd = {$urandom(), $urandom()}; py = rnd[59:0];
    send(0, px, w);
    n = 0;
    while (!a_eof && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("bp_eof_seen", 64'(a_eof), 64'd1);
    check("bp_buffer_empty", 64'(a_ready), 64'd1);
    send(0, py, w);
    check("bp_wait", 64'(w), 64'd0);
    wait_idle(0);
    check("bp_run", 64'(a_last_run), 64'd120);
    check("bp_loader", 64'(a_ld), 64'(py));

    // backpressure with three packages offered continuously
    f0 = a_frames;
    send(0, 60'h0123456789ABCDE, w);
    send(0, 60'hFEDCBA987654321, w);
    check("t4_ready_low", 64'(a_ready), 64'd0);
    check("t4_busy", 64'(a_busy), 64'd1);
    send(0, 60'h0F0F0F0F0F0F0F0, w);
    check("t4_ready_return", 64'(w), 64'd60);
    wait_idle(0);
    check("t4_run", 64'(a_last_run), 64'd180);
    check("t4_frames", 64'(a_frames - f0), 64'd3);
    check("t4_q_empty", 64'(a_exp_q.size()), 64'd0);

    // gap instance: exactly three idle cycles between frames
    send(1, PAT_A, w);
    send(1, PAT_5, w);
    wait_idle(1);
    check("t3_gap", 64'(b_last_gap), 64'd3);
    check("t3_frames", 64'(b_frames), 64'd2);
    check("t3_loader", 64'(b_ld), 64'(PAT_5));

    // reset at the 30th bit with the buffer full
    rnd = {$urandom(), $urandom()}; px = rnd[59:0];
    rnd = {$urandom(), $urandom()}; py = rnd[59:0];
    rnd = {$urandom(), $urandom()}; pz = rnd[59:0];
    send(0, px, w);
    send(0, py, w);
    repeat (28) @(posedge clk);
    #1;
    check("t5_pre_state", 64'({a_sv, a_ready}), 64'd2);
    #1 reset = 1'b1;
    #1;
    check("t5_async_outputs", 64'({a_so, a_sv, a_sof, a_eof, a_busy}), 64'd0);
    check("t5_async_ready", 64'(a_ready), 64'd1);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("t5_quiet", 64'({a_sv, a_busy, a_ready}), 64'd1);
    end
    send(0, pz, w);
    check("t5_wait", 64'(w), 64'd0);
    wait_idle(0);
    check("t5_run", 64'(a_last_run), 64'd60);
    check("t5_loader", 64'(a_ld), 64'(pz));

    // 2-bit packages back to back
    send(2, 60'd2, w);
    send(2, 60'd1, w);
    wait_idle(2);
    check("t6_seq", 64'(c_seq[3:0]), 64'(4'b1001));
    check("t6_run", 64'(c_last_run), 64'd4);
    check("t6_frames", 64'(c_frames), 64'd2);

    check("end_a_q", 64'(a_exp_q.size()), 64'd0);
    check("end_b_q", 64'(b_exp_q.size()), 64'd0);
    check("end_c_q", 64'(c_exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
